tb_clk_rst_ctrl: RTL and testbench

- Command-driven controller that produces the clock-control and reset stimulus consumed by the DUT-facing test interface.
- Drives `manual`, `clk` and `nEnable` (the `clk_ctrl_t` fields) plus the DUT reset.
- Test sequences issue RESET / RUN / STEP commands through a valid/ready handshake and receive a done pulse on completion.
- Sits in the tb wrapper between test sequences and the interface. It is clocked by the free-running generator clock, never by the gated `dut_clk`.

---
 rtl/tb_clk_rst_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_tb_clk_rst_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tb_clk_rst_ctrl.sv
// rtl/tb_clk_rst_ctrl.sv - command-driven clock gating / DUT reset controller (optional counter: TB_CLK_CTRL_CYCLE_CNT_EN)
module tb_clk_rst_ctrl #(
    parameter int CNT_W    = 16,
    parameter int HALF_PER = 2,
    parameter int RST_MIN  = 4
) (
    input  logic             tb_clk,
    input  logic             nReset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             ctrl_manual,
    output logic             ctrl_clk,
    output logic             ctrl_nEnable,
    output logic             dut_nReset,
    output logic [31:0]      cycle_cnt,
    input  logic             cycle_clr
);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_STEP_HI, S_STEP_LO} state_t;

    localparam logic [1:0]       OP_RESET  = 2'd0;
    localparam logic [1:0]       OP_RUN    = 2'd1;
    localparam logic [1:0]       OP_STEP   = 2'd2;
    localparam logic [CNT_W-1:0] RST_MIN_C = CNT_W'(RST_MIN);
    localparam logic [7:0]       HALF_LAST = 8'(HALF_PER - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cmd_len;
    logic [7:0]       half_q, half_d;
    logic             cont_q, cont_d;
    logic             done_q, done_d;
    logic             manual_q, manual_d;
    logic             clk_q, clk_d;
    logic             nen_q, nen_d;
    logic             rst_q, rst_d;
    logic             nen_port_q;

    assign cmd_len = (cmd_count == '0) ? CNT_W'(1) : cmd_count;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        cont_d   = cont_q;
        done_d   = 1'b0;
        manual_d = manual_q;
        clk_d    = clk_q;
        nen_d    = nen_q;
        rst_d    = rst_q;
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            nen_d    = 1'b1;
            manual_d = 1'b0;
            clk_d    = 1'b0;
            if (state_q == S_RST) rst_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && !abort) begin
                        case (cmd_op)
                            OP_RESET: begin
                                state_d = S_RST;
                                cnt_d   = ((cmd_len > RST_MIN_C) ? cmd_len : RST_MIN_C) - CNT_W'(1);
                                rst_d   = 1'b0;
                                nen_d   = 1'b1;
                            end
                            OP_RUN: begin
                                state_d = S_RUN;
                                cnt_d   = cmd_len - CNT_W'(1);
                                cont_d  = (cmd_count == '0);
                                nen_d   = 1'b0;
                            end
                            OP_STEP: begin
                                state_d  = S_STEP_HI;
                                cnt_d    = cmd_len - CNT_W'(1);
                                half_d   = HALF_LAST;
                                manual_d = 1'b1;
                                clk_d    = 1'b1;
                                nen_d    = 1'b0;
                            end
                            default: begin
                                nen_d  = 1'b1;
                                done_d = 1'b1;
                            end
                        endcase
                    end
                end
                S_RST: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        rst_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_RUN: begin
                    // A zero count leaves cont_q set so only abort can end the run.
                    if (!cont_q) begin
                        if (cnt_q == '0) begin
                            state_d = S_IDLE;
                            nen_d   = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                S_STEP_HI: begin
                    if (half_q == '0) begin
                        state_d = S_STEP_LO;
                        half_d  = HALF_LAST;
                        clk_d   = 1'b0;
                    end else begin
                        half_d = half_q - 8'd1;
                    end
                end
                S_STEP_LO: begin
                    if (half_q != '0) begin
                        half_d = half_q - 8'd1;
                    end else if (cnt_q == '0) begin
                        state_d  = S_IDLE;
                        manual_d = 1'b0;
                        clk_d    = 1'b0;
                        nen_d    = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_STEP_HI;
                        cnt_d   = cnt_q - CNT_W'(1);
                        half_d  = HALF_LAST;
                        clk_d   = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge tb_clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            half_q   <= '0;
            cont_q   <= 1'b0;
            done_q   <= 1'b0;
            manual_q <= 1'b0;
            clk_q    <= 1'b0;
            nen_q    <= 1'b1;
            rst_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            cont_q   <= cont_d;
            done_q   <= done_d;
            manual_q <= manual_d;
            clk_q    <= clk_d;
            nen_q    <= nen_d;
            rst_q    <= rst_d;
        end
    end

    // Retime the enable on the falling edge so the gated clock never sees a runt pulse.
    always_ff @(negedge tb_clk or negedge nReset) begin
        if (!nReset) nen_port_q <= 1'b1;
        else         nen_port_q <= nen_q;
    end

`ifdef TB_CLK_CTRL_CYCLE_CNT_EN
    logic [31:0] cyc_q;
    always_ff @(posedge tb_clk or negedge nReset) begin
        if (!nReset) begin
            cyc_q <= '0;
        end else if (cycle_clr) begin
            cyc_q <= '0;
        end else if ((state_q == S_RUN || (clk_d && !clk_q)) && cyc_q != 32'hFFFF_FFFF) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end
    assign cycle_cnt = cyc_q;
`else
    logic unused_cycle_clr;
    assign unused_cycle_clr = cycle_clr;
    assign cycle_cnt        = '0;
`endif

    assign cmd_ready    = (state_q == S_IDLE) && !abort;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign ctrl_manual  = manual_q;
    assign ctrl_clk     = clk_q;
    assign ctrl_nEnable = nen_port_q;
    assign dut_nReset   = rst_q;

endmodule

// File: tb/tb_tb_clk_rst_ctrl.sv
// tb/tb_tb_clk_rst_ctrl.sv - self-checking bench for tb_clk_rst_ctrl
module tb_tb_clk_rst_ctrl;

    logic        tb_clk = 1'b0;
    logic        nReset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_count = 16'd0;
    logic        abort = 1'b0;
    logic        busy, done, ctrl_manual, ctrl_clk, ctrl_nEnable, dut_nReset;
    logic [31:0] cycle_cnt;
    logic        cycle_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    tb_clk_rst_ctrl #(.CNT_W(16), .HALF_PER(2), .RST_MIN(4)) dut (
        .tb_clk(tb_clk), .nReset(nReset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .abort(abort), .busy(busy), .done(done),
        .ctrl_manual(ctrl_manual), .ctrl_clk(ctrl_clk), .ctrl_nEnable(ctrl_nEnable),
        .dut_nReset(dut_nReset), .cycle_cnt(cycle_cnt), .cycle_clr(cycle_clr)
    );

    always #5 tb_clk = ~tb_clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] cnt;
        int          busy_n;
        int          rst_low;
        int          nen_low;
        int          rises;
        int          hi;
        int          man;
        int          cyc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #2;
    endtask

    function automatic int cyc_exp(input int n);
`ifdef TB_CLK_CTRL_CYCLE_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    // The gated enable port may only move while tb_clk is low.
    always @(ctrl_nEnable) begin
        if (nReset === 1'b1) chk("nen_edge_in_low_phase", {31'd0, tb_clk}, 32'd0);
    end

    task automatic run_vec(input int idx, input vec_t v);
        int busy_n, rst_low, nen_low, rises, hi, man, dn;
        logic prev_clk;
        logic [31:0] c0;
        busy_n = 0; rst_low = 0; nen_low = 0; rises = 0; hi = 0; man = 0; dn = 0;
        prev_clk = 1'b0;
        chk($sformatf("v%0d_ready", idx), {31'd0, cmd_ready}, 32'd1);
        c0 = cycle_cnt;
        cmd_valid = 1'b1; cmd_op = v.op; cmd_count = v.cnt;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (busy) busy_n++;
            if (!dut_nReset) rst_low++;
            if (!ctrl_nEnable) nen_low++;
            if (ctrl_clk && !prev_clk) rises++;
            if (ctrl_clk) hi++;
            if (ctrl_manual) man++;
            prev_clk = ctrl_clk;
            if (done) begin
                dn = 1;
                break;
            end
            tick();
        end
        chk($sformatf("v%0d_done_seen", idx), dn, 1);
        chk($sformatf("v%0d_busy_cycles", idx), busy_n, v.busy_n);
        chk($sformatf("v%0d_rst_low", idx), rst_low, v.rst_low);
        chk($sformatf("v%0d_nen_low", idx), nen_low, v.nen_low);
        chk($sformatf("v%0d_clk_rises", idx), rises, v.rises);
        chk($sformatf("v%0d_clk_high", idx), hi, v.hi);
        chk($sformatf("v%0d_manual", idx), man, v.man);
        chk($sformatf("v%0d_cycle_cnt", idx), cycle_cnt - c0, cyc_exp(v.cyc));
        tick();
        chk($sformatf("v%0d_done_once", idx), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d_nen_after", idx), {31'd0, ctrl_nEnable}, 32'd1);
        chk($sformatf("v%0d_idle_after", idx), {31'd0, busy}, 32'd0);
    endtask

    vec_t vecs[8];
    int   done_cnt;

    initial begin
        vecs[0] = '{2'd0, 16'd2,  4, 4, 0,  0, 0, 0,  0};
        vecs[1] = '{2'd0, 16'd0,  4, 4, 0,  0, 0, 0,  0};
        vecs[2] = '{2'd0, 16'd6,  6, 6, 0,  0, 0, 0,  0};
        vecs[3] = '{2'd1, 16'd10, 10, 0, 10, 0, 0, 0, 10};
        vecs[4] = '{2'd1, 16'd1,  1, 0, 1,  0, 0, 0,  1};
        vecs[5] = '{2'd2, 16'd3,  12, 0, 12, 3, 6, 12, 3};
        vecs[6] = '{2'd2, 16'd0,  4, 0, 4,  1, 2, 4,  1};
        vecs[7] = '{2'd3, 16'd0,  0, 0, 0,  0, 0, 0,  0};

        tick();
        tick();
        chk("rst_dut_nReset", {31'd0, dut_nReset}, 32'd0);
        nReset = 1'b1;
        tick();
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_nen", {31'd0, ctrl_nEnable}, 32'd1);
        chk("idle_dut_nReset", {31'd0, dut_nReset}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_manual_clk", {30'd0, ctrl_manual, ctrl_clk}, 32'd0);
        chk("idle_cycle_cnt", cycle_cnt, 32'd0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Abort in IDLE is ignored and blocks acceptance of a simultaneous command.
        abort = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_count = 16'd3;
        #1;
        chk("idle_abort_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        abort = 1'b0; cmd_valid = 1'b0;
        chk("idle_abort_busy", {31'd0, busy}, 32'd0);
        chk("idle_abort_done", {31'd0, done}, 32'd0);

        cycle_clr = 1'b1;
        tick();
        cycle_clr = 1'b0;
        chk("cycle_clr", cycle_cnt, 32'd0);

        // Continuous RUN, aborted after 50 cycles with a competing command.
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_count = 16'd0;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        chk("run0_still_busy", {31'd0, busy}, 32'd1);
        chk("run0_nen_low", {31'd0, ctrl_nEnable}, 32'd0);
        abort = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_count = 16'd5;
        #1;
        chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        abort = 1'b0; cmd_valid = 1'b0;
        chk("abort_done", {31'd0, done}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cycle_cnt", cycle_cnt, cyc_exp(51));
        tick();
        chk("abort_nen_resumed", {31'd0, ctrl_nEnable}, 32'd1);
        chk("abort_not_accepted", {31'd0, busy}, 32'd0);
        chk("abort_done_once", {31'd0, done}, 32'd0);

        // Reset asserted during the second pulse of a 5-pulse STEP.
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_count = 16'd5;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("step2_clk_high", {30'd0, ctrl_manual, ctrl_clk}, 32'd3);
        nReset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_manual_clk", {30'd0, ctrl_manual, ctrl_clk}, 32'd0);
        chk("mid_rst_nen", {31'd0, ctrl_nEnable}, 32'd1);
        chk("mid_rst_dut_nReset", {31'd0, dut_nReset}, 32'd0);
        chk("mid_rst_cycle_cnt", cycle_cnt, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) done_cnt++;
        end
        nReset = 1'b1;
        tick();
        if (done) done_cnt++;
        chk("mid_rst_no_done", done_cnt, 0);
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_count = 16'd1;
        tick();
        cmd_valid = 1'b0;
        chk("post_rst_run_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("post_rst_run_done", {31'd0, done}, 32'd1);
        chk("post_rst_run_cycle_cnt", cycle_cnt, cyc_exp(1));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
